// File: rtl/s32x_sdr_arb.sv
// Arbiter sharing one SDRAM port between the master and slave SH-2 CPUs.
// Each access is granted from IDLE and runs IDLE -> BUSY -> DONE, holding the owner's request on the SDRAM bus until it completes.
module s32x_sdr_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_m_cs,
    input  logic [16:0] i_m_a,
    input  logic [15:0] i_m_di,
    input  logic [1:0]  i_m_we,
    input  logic        i_m_rd,
    output logic [15:0] o_m_do,
    output logic        o_m_wait_n,
    input  logic        i_s_cs,
    input  logic [16:0] i_s_a,
    input  logic [15:0] i_s_di,
    input  logic [1:0]  i_s_we,
    input  logic        i_s_rd,
    output logic [15:0] o_s_do,
    output logic        o_s_wait_n,
    output logic [16:0] o_sdr_a,
    output logic [15:0] o_sdr_do,
    output logic [1:0]  o_sdr_we,
    output logic        o_sdr_rd,
    output logic        o_sdr_cs,
    input  logic [15:0] i_sdr_di,
    input  logic        i_sdr_wait
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // owner/last encoding: 0 = master, 1 = slave
    state_t      r_state, w_state_nx;
    logic        r_owner, w_owner_nx;
    logic        r_last,  w_last_nx;
    logic [16:0] r_sdr_a, w_sdr_a_nx;
    logic [15:0] r_sdr_do, w_sdr_do_nx;
    logic [1:0]  r_sdr_we, w_sdr_we_nx;
    logic        r_sdr_rd, w_sdr_rd_nx;
    logic        r_sdr_cs, w_sdr_cs_nx;
    logic [15:0] r_m_do, w_m_do_nx;
    logic [15:0] r_s_do, w_s_do_nx;
    logic        w_grant_s;
    logic        w_owner_cs;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_sdr_a  <= '0;
            r_sdr_do <= '0;
            r_sdr_we <= '0;
            r_sdr_rd <= 1'b0;
            r_sdr_cs <= 1'b0;
            r_m_do   <= '0;
            r_s_do   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_owner  <= w_owner_nx;
            r_last   <= w_last_nx;
            r_sdr_a  <= w_sdr_a_nx;
            r_sdr_do <= w_sdr_do_nx;
            r_sdr_we <= w_sdr_we_nx;
            r_sdr_rd <= w_sdr_rd_nx;
            r_sdr_cs <= w_sdr_cs_nx;
            r_m_do   <= w_m_do_nx;
            r_s_do   <= w_s_do_nx;
        end
    end

    assign w_owner_cs = r_owner ? i_s_cs : i_m_cs;

    always_comb begin
        w_state_nx  = r_state;
        w_owner_nx  = r_owner;
        w_last_nx   = r_last;
        w_sdr_a_nx  = r_sdr_a;
        w_sdr_do_nx = r_sdr_do;
        w_sdr_we_nx = r_sdr_we;
        w_sdr_rd_nx = r_sdr_rd;
        w_sdr_cs_nx = r_sdr_cs;
        w_m_do_nx   = r_m_do;
        w_s_do_nx   = r_s_do;
        w_grant_s   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_m_cs || i_s_cs) begin
                    // on a tie, round-robin favours whoever was not served last
                    if (i_m_cs && i_s_cs)
                        w_grant_s = RR_EN ? ~r_last : 1'b0;
                    else
                        w_grant_s = i_s_cs;
                    w_state_nx  = ST_BUSY;
                    w_owner_nx  = w_grant_s;
                    w_sdr_cs_nx = 1'b1;
                    w_sdr_a_nx  = w_grant_s ? i_s_a  : i_m_a;
                    w_sdr_do_nx = w_grant_s ? i_s_di : i_m_di;
                    w_sdr_we_nx = w_grant_s ? i_s_we : i_m_we;
                    w_sdr_rd_nx = w_grant_s ? i_s_rd : i_m_rd;
                end
            end
            ST_BUSY: begin
                if (!i_sdr_wait) begin
                    w_sdr_cs_nx = 1'b0;
                    if (r_sdr_rd) begin
                        if (r_owner)
                            w_s_do_nx = i_sdr_di;
                        else
                            w_m_do_nx = i_sdr_di;
                    end
                    w_last_nx  = r_owner;
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!w_owner_cs)
                    w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // the owner is released only once its access has finished
    assign o_m_wait_n = ~(i_m_cs & ~((r_state == ST_DONE) & ~r_owner));
    assign o_s_wait_n = ~(i_s_cs & ~((r_state == ST_DONE) &  r_owner));

    assign o_m_do   = r_m_do;
    assign o_s_do   = r_s_do;
    assign o_sdr_a  = r_sdr_a;
    assign o_sdr_do = r_sdr_do;
    assign o_sdr_we = r_sdr_we;
    assign o_sdr_rd = r_sdr_rd;
    assign o_sdr_cs = r_sdr_cs;

endmodule

// File: tb/tb_s32x_sdr_arb.sv
// Bench for s32x_sdr_arb: cycle-by-cycle vector table on a round-robin instance,
// then a grant-order run comparing round-robin and fixed-priority instances.
module tb_s32x_sdr_arb;

    localparam logic [16:0] MA = 17'h00100;
    localparam logic [16:0] SA = 17'h00200;
    localparam logic [15:0] MD = 16'h1111;
    localparam logic [15:0] SD = 16'h12AB;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_cs, s_cs, m_cs0, s_cs0;
    logic [16:0] m_a, s_a;
    logic [15:0] m_di, s_di;
    logic [1:0]  m_we, s_we;
    logic        m_rd, s_rd;
    logic [15:0] sdr_di;
    logic        sdr_wait;

    logic [15:0] m_do, s_do, m_do0, s_do0;
    logic        m_wn, s_wn, m_wn0, s_wn0;
    logic [16:0] sdr_a, sdr_a0;
    logic [15:0] sdr_do, sdr_do0;
    logic [1:0]  sdr_we, sdr_we0;
    logic        sdr_rd, sdr_rd0, sdr_cs, sdr_cs0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    s32x_sdr_arb #(.RR_EN(1'b1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m_cs(m_cs), .i_m_a(m_a), .i_m_di(m_di), .i_m_we(m_we), .i_m_rd(m_rd),
        .o_m_do(m_do), .o_m_wait_n(m_wn),
        .i_s_cs(s_cs), .i_s_a(s_a), .i_s_di(s_di), .i_s_we(s_we), .i_s_rd(s_rd),
        .o_s_do(s_do), .o_s_wait_n(s_wn),
        .o_sdr_a(sdr_a), .o_sdr_do(sdr_do), .o_sdr_we(sdr_we), .o_sdr_rd(sdr_rd),
        .o_sdr_cs(sdr_cs), .i_sdr_di(sdr_di), .i_sdr_wait(sdr_wait)
    );

    s32x_sdr_arb #(.RR_EN(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_m_cs(m_cs0), .i_m_a(m_a), .i_m_di(m_di), .i_m_we(m_we), .i_m_rd(m_rd),
        .o_m_do(m_do0), .o_m_wait_n(m_wn0),
        .i_s_cs(s_cs0), .i_s_a(s_a), .i_s_di(s_di), .i_s_we(s_we), .i_s_rd(s_rd),
        .o_s_do(s_do0), .o_s_wait_n(s_wn0),
        .o_sdr_a(sdr_a0), .o_sdr_do(sdr_do0), .o_sdr_we(sdr_we0), .o_sdr_rd(sdr_rd0),
        .o_sdr_cs(sdr_cs0), .i_sdr_di(sdr_di), .i_sdr_wait(sdr_wait)
    );

    typedef struct {
        logic        rst;
        logic        mcs, mrd;
        logic [1:0]  mwe;
        logic        scs, srd;
        logic [1:0]  swe;
        logic        wt;
        logic [15:0] di;
        logic [70:0] exp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rst_i, input logic mcs, input logic mrd, input logic [1:0] mwe,
        input logic scs, input logic srd, input logic [1:0] swe,
        input logic wt, input logic [15:0] di,
        input logic ecs, input logic [16:0] ea, input logic erd, input logic [1:0] ewe,
        input logic [15:0] edo, input logic emwn, input logic eswn,
        input logic [15:0] emdo, input logic [15:0] esdo);
        vec_t v;
        v.rst = rst_i; v.mcs = mcs; v.mrd = mrd; v.mwe = mwe;
        v.scs = scs; v.srd = srd; v.swe = swe; v.wt = wt; v.di = di;
        v.exp = {ecs, ea, erd, ewe, edo, emwn, eswn, emdo, esdo};
        return v;
    endfunction

    logic [70:0] act;
    logic        pm1, ps1, pm0, ps0;
    int          n1, n0, cyc;
    logic        got1[4], got0[4];
    logic        exp1[4], exp0[4];

    initial begin
        rst = 1'b1;
        m_cs = 0; s_cs = 0; m_cs0 = 0; s_cs0 = 0;
        m_a = MA; s_a = SA; m_di = MD; s_di = SD;
        m_we = 0; s_we = 0; m_rd = 0; s_rd = 0;
        sdr_di = 0; sdr_wait = 0;

        // reset with M requesting
        vq.push_back(mk(1, 1,0,2'b00, 0,0,2'b00, 0,16'h0,    0,17'h0,0,2'b00,16'h0, 0,1, 16'h0,16'h0));
        // single master read, three wait cycles
        vq.push_back(mk(0, 1,1,2'b00, 0,0,2'b00, 1,16'h0,    0,17'h0,0,2'b00,16'h0, 0,1, 16'h0,16'h0));
        vq.push_back(mk(0, 1,1,2'b00, 0,0,2'b00, 1,16'h0,    1,MA,1,2'b00,MD,       0,1, 16'h0,16'h0));
        vq.push_back(mk(0, 1,1,2'b00, 0,0,2'b00, 1,16'h0,    1,MA,1,2'b00,MD,       0,1, 16'h0,16'h0));
        vq.push_back(mk(0, 1,1,2'b00, 0,0,2'b00, 1,16'h0,    1,MA,1,2'b00,MD,       0,1, 16'h0,16'h0));
        vq.push_back(mk(0, 1,1,2'b00, 0,0,2'b00, 0,16'hBEEF, 1,MA,1,2'b00,MD,       0,1, 16'h0,16'h0));
        vq.push_back(mk(0, 1,1,2'b00, 0,0,2'b00, 0,16'hBEEF, 0,MA,1,2'b00,MD,       1,1, 16'hBEEF,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 0,0,2'b00, 0,16'h0,    0,MA,1,2'b00,MD,       1,1, 16'hBEEF,16'h0));
        // reset, then tie: M first, S after M drops; S byte write
        vq.push_back(mk(1, 0,0,2'b00, 0,0,2'b00, 0,16'h0,    0,17'h0,0,2'b00,16'h0, 1,1, 16'h0,16'h0));
        vq.push_back(mk(0, 1,0,2'b11, 1,0,2'b10, 0,16'h0,    0,17'h0,0,2'b00,16'h0, 0,0, 16'h0,16'h0));
        vq.push_back(mk(0, 1,0,2'b11, 1,0,2'b10, 0,16'h0,    1,MA,0,2'b11,MD,       0,0, 16'h0,16'h0));
        vq.push_back(mk(0, 1,0,2'b11, 1,0,2'b10, 0,16'h0,    0,MA,0,2'b11,MD,       1,0, 16'h0,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,0,2'b10, 0,16'h0,    0,MA,0,2'b11,MD,       1,0, 16'h0,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,0,2'b10, 0,16'h0,    0,MA,0,2'b11,MD,       1,0, 16'h0,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,0,2'b10, 0,16'h0,    1,SA,0,2'b10,SD,       1,0, 16'h0,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,0,2'b10, 0,16'h0,    0,SA,0,2'b10,SD,       1,1, 16'h0,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 0,0,2'b00, 0,16'h0,    0,SA,0,2'b10,SD,       1,1, 16'h0,16'h0));
        // M withdraws mid-BUSY while S is pending
        vq.push_back(mk(0, 1,1,2'b00, 1,1,2'b00, 1,16'h0,    0,SA,0,2'b10,SD,       0,0, 16'h0,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,1,2'b00, 1,16'h0,    1,MA,1,2'b00,MD,       1,0, 16'h0,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,1,2'b00, 1,16'h0,    1,MA,1,2'b00,MD,       1,0, 16'h0,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,1,2'b00, 0,16'h5A5A, 1,MA,1,2'b00,MD,       1,0, 16'h0,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,1,2'b00, 0,16'h5A5A, 0,MA,1,2'b00,MD,       1,0, 16'h5A5A,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,1,2'b00, 0,16'h0,    0,MA,1,2'b00,MD,       1,0, 16'h5A5A,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,1,2'b00, 0,16'hC3C3, 1,SA,1,2'b00,SD,       1,0, 16'h5A5A,16'h0));
        vq.push_back(mk(0, 0,0,2'b00, 1,1,2'b00, 0,16'h0,    0,SA,1,2'b00,SD,       1,1, 16'h5A5A,16'hC3C3));
        vq.push_back(mk(0, 0,0,2'b00, 0,0,2'b00, 0,16'h0,    0,SA,1,2'b00,SD,       1,1, 16'h5A5A,16'hC3C3));
        // reset mid-BUSY aborts the access; next tie goes to M
        vq.push_back(mk(0, 1,1,2'b00, 0,0,2'b00, 1,16'h0,    0,SA,1,2'b00,SD,       0,1, 16'h5A5A,16'hC3C3));
        vq.push_back(mk(1, 1,1,2'b00, 0,0,2'b00, 1,16'h0,    0,17'h0,0,2'b00,16'h0, 0,1, 16'h0,16'h0));
        vq.push_back(mk(0, 1,0,2'b00, 1,0,2'b00, 0,16'h0,    0,17'h0,0,2'b00,16'h0, 0,0, 16'h0,16'h0));
        vq.push_back(mk(0, 1,0,2'b00, 1,0,2'b00, 0,16'h0,    1,MA,0,2'b00,MD,       0,0, 16'h0,16'h0));

        foreach (vq[i]) begin
            @(posedge clk); #1;
            rst = vq[i].rst; m_cs = vq[i].mcs; m_rd = vq[i].mrd; m_we = vq[i].mwe;
            s_cs = vq[i].scs; s_rd = vq[i].srd; s_we = vq[i].swe;
            sdr_wait = vq[i].wt; sdr_di = vq[i].di;
            #3;
            act = {sdr_cs, sdr_a, sdr_rd, sdr_we, sdr_do, m_wn, s_wn, m_do, s_do};
            checks++;
            if (act !== vq[i].exp) begin
                errors++;
                $display("FAIL vec%0d {cs,a,rd,we,do,mwn,swn,mdo,sdo} actual=%h expected=%h",
                         i, act, vq[i].exp);
            end
        end

        // grant order with both requesters always coming back
        exp1[0] = 0; exp1[1] = 1; exp1[2] = 0; exp1[3] = 1;
        exp0[0] = 0; exp0[1] = 0; exp0[2] = 0; exp0[3] = 0;
        @(posedge clk); #1;
        rst = 1; m_cs = 0; s_cs = 0; m_rd = 0; s_rd = 0; m_we = 0; s_we = 0;
        sdr_wait = 0; sdr_di = 0;
        @(posedge clk); #1;
        rst = 0; m_cs = 1; s_cs = 1; m_cs0 = 1; s_cs0 = 1;
        pm1 = 0; ps1 = 0; pm0 = 0; ps0 = 0;
        n1 = 0; n0 = 0; cyc = 0;
        while ((n1 < 4 || n0 < 4) && cyc < 100) begin
            @(posedge clk); #1;
            m_cs  = !(m_cs  && pm1);
            s_cs  = !(s_cs  && ps1);
            m_cs0 = !(m_cs0 && pm0);
            s_cs0 = !(s_cs0 && ps0);
            #3;
            if (sdr_cs && n1 < 4) begin got1[n1] = (sdr_a != MA); n1++; end
            if (sdr_cs0 && n0 < 4) begin got0[n0] = (sdr_a0 != MA); n0++; end
            pm1 = m_wn; ps1 = s_wn; pm0 = m_wn0; ps0 = s_wn0;
            cyc++;
        end
        checks++;
        if (n1 < 4 || n0 < 4) begin
            errors++;
            $display("FAIL grant_timeout rr_grants=%0d fixed_grants=%0d required=4", n1, n0);
        end
        for (int k = 0; k < n1; k++) begin
            checks++;
            if (got1[k] !== exp1[k]) begin
                errors++;
                $display("FAIL rr_grant%0d actual_owner=%0b expected_owner=%0b (0=M,1=S)", k, got1[k], exp1[k]);
            end
        end
        for (int k = 0; k < n0; k++) begin
            checks++;
            if (got0[k] !== exp0[k]) begin
                errors++;
                $display("FAIL fixed_grant%0d actual_owner=%0b expected_owner=%0b (0=M,1=S)", k, got0[k], exp0[k]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
